// File: rtl/bist_controller_if.sv
// Handshake and result bundle between the BIST sequencer and its host/chain.
interface bist_controller_if #(
    parameter int SIG_W = 5,
    parameter int CNT_W = 16
);
    logic             start;
    logic             learn;
    logic             abort;
    logic [SIG_W-1:0] signature;
    logic             chain_clr;
    logic             chain_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SIG_W-1:0] golden;
    logic [SIG_W-1:0] sig_cap;
    logic [CNT_W-1:0] cycle_cnt;

    // Host / chain side: issues requests and supplies the MISR signature.
    modport master (
        output start, learn, abort, signature,
        input  chain_clr, chain_en, busy, done, pass, golden, sig_cap, cycle_cnt
    );

    // Controller side.
    modport slave (
        input  start, learn, abort, signature,
        output chain_clr, chain_en, busy, done, pass, golden, sig_cap, cycle_cnt
    );
endinterface

// File: rtl/bist_controller.sv
// Sequencer for the LFSR -> adder4 -> MISR BIST chain: clears the chain,
// enables it for TEST_CYCLES clocks, captures the signature, then either
// checks it against the golden register or learns it as the new golden.
module bist_controller #(
    parameter int               TEST_CYCLES    = 64,
    parameter int               CNT_W          = 16,
    parameter int               SIG_W          = 5,
    parameter logic [SIG_W-1:0] GOLDEN_DEFAULT = 5'h16
) (
    input  logic               clk,
    input  logic               rst,
    bist_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_EVAL  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TEST_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_chain_clr;
    logic             w_chain_en;
    logic             w_busy;

    logic             r_learn;
    logic             r_done;
    logic             r_pass;
    logic [SIG_W-1:0] r_golden;
    logic [SIG_W-1:0] r_sig_cap;
    logic [CNT_W-1:0] r_cycle_cnt;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and chain controls decoded purely from the current state.
    always_comb begin
        w_next_state = r_state;
        w_chain_clr  = 1'b0;
        w_chain_en   = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_chain_clr  = 1'b1;
                w_next_state = bus.abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                w_chain_en = 1'b1;
                if (bus.abort) begin
                    w_next_state = S_IDLE;
                end else if (r_cycle_cnt == LAST_CNT) begin
                    w_next_state = S_EVAL;
                end
            end
            S_EVAL: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Run bookkeeping: learn latch, cycle counter, capture, verdict and golden.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_learn     <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_golden    <= GOLDEN_DEFAULT;
            r_sig_cap   <= '0;
            r_cycle_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_learn <= bus.learn;
                        r_pass  <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_cycle_cnt <= '0;
                    if (bus.abort) begin
                        r_pass <= 1'b0;
                    end
                end
                S_RUN: begin
                    // The aborting cycle still had the chain enabled, so it is counted.
                    r_cycle_cnt <= r_cycle_cnt + 1'b1;
                    if (bus.abort) begin
                        r_pass <= 1'b0;
                    end
                end
                S_EVAL: begin
                    if (bus.abort) begin
                        r_pass <= 1'b0;
                    end else begin
                        r_sig_cap <= bus.signature;
                        r_done    <= 1'b1;
                        if (r_learn) begin
                            r_golden <= bus.signature;
                            r_pass   <= 1'b1;
                        end else begin
                            r_pass   <= (bus.signature == r_golden);
                        end
                    end
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign bus.chain_clr = w_chain_clr;
    assign bus.chain_en  = w_chain_en;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.golden    = r_golden;
    assign bus.sig_cap   = r_sig_cap;
    assign bus.cycle_cnt = r_cycle_cnt;

endmodule

// File: tb/tb_bist_controller.sv
// Directed bench for bist_controller; the host drives the signature directly
// in place of the LFSR/adder/MISR chain.
module tb_bist_controller;

    localparam int SIG_W = 5;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    bist_controller_if #(.SIG_W(SIG_W), .CNT_W(CNT_W)) bif ();

    bist_controller #(
        .TEST_CYCLES(64),
        .CNT_W(CNT_W),
        .SIG_W(SIG_W),
        .GOLDEN_DEFAULT(5'h16)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Edge e0: start sampled in IDLE. learn is flipped right after to prove it is latched.
    task automatic pulse_start(input logic lrn, input logic ab);
        bif.start = 1'b1;
        bif.learn = lrn;
        bif.abort = ab;
        tick();
        bif.start = 1'b0;
        bif.learn = ~lrn;
        bif.abort = 1'b0;
    endtask

    // Observes 70 edges after e0; optionally re-asserts start before edge restart_at.
    task automatic run_measure(input int restart_at, output int en_cnt, output int clr_cnt,
                               output int done_cnt, output int done_edge);
        en_cnt = 0; clr_cnt = 0; done_cnt = 0; done_edge = -1;
        for (int k = 1; k <= 70; k++) begin
            bif.start = (k == restart_at);
            tick();
            if (bif.chain_en)  en_cnt++;
            if (bif.chain_clr) clr_cnt++;
            if (bif.done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = k;
            end
        end
        bif.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bif.start = 1'b0; bif.learn = 1'b0; bif.abort = 1'b0; bif.signature = '0;
        repeat (3) tick();
        total++; if (bif.chain_clr !== 1'b0) begin bad++; $display("FAIL reset_chain_clr: got %b want 0", bif.chain_clr); end
        total++; if (bif.chain_en  !== 1'b0) begin bad++; $display("FAIL reset_chain_en: got %b want 0", bif.chain_en); end
        total++; if (bif.busy      !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bif.busy); end
        total++; if (bif.done      !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bif.done); end
        total++; if (bif.pass      !== 1'b0) begin bad++; $display("FAIL reset_pass: got %b want 0", bif.pass); end
        total++; if (bif.golden    !== 5'h16) begin bad++; $display("FAIL reset_golden: got %h want 16", bif.golden); end
        total++; if (bif.sig_cap   !== 5'h00) begin bad++; $display("FAIL reset_sig_cap: got %h want 00", bif.sig_cap); end
        total++; if (bif.cycle_cnt !== 16'd0) begin bad++; $display("FAIL reset_cycle_cnt: got %0d want 0", bif.cycle_cnt); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_check_pass();
        int en, clr, dn, de;
        bif.signature = 5'h16;
        pulse_start(1'b0, 1'b0);
        total++; if (bif.chain_clr !== 1'b1) begin bad++; $display("FAIL cp_clear_after_start: got %b want 1", bif.chain_clr); end
        total++; if (bif.busy !== 1'b1) begin bad++; $display("FAIL cp_busy_after_start: got %b want 1", bif.busy); end
        run_measure(0, en, clr, dn, de);
        total++; if (en !== 64) begin bad++; $display("FAIL cp_en_cycles: got %0d want 64", en); end
        total++; if (clr !== 0) begin bad++; $display("FAIL cp_clr_during_run: got %0d want 0", clr); end
        total++; if (dn !== 1) begin bad++; $display("FAIL cp_done_pulses: got %0d want 1", dn); end
        total++; if (de !== 66) begin bad++; $display("FAIL cp_done_edge: got %0d want 66", de); end
        total++; if (bif.sig_cap !== 5'h16) begin bad++; $display("FAIL cp_sig_cap: got %h want 16", bif.sig_cap); end
        total++; if (bif.pass !== 1'b1) begin bad++; $display("FAIL cp_pass: got %b want 1", bif.pass); end
        total++; if (bif.cycle_cnt !== 16'd64) begin bad++; $display("FAIL cp_cycle_cnt: got %0d want 64", bif.cycle_cnt); end
        total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL cp_busy_end: got %b want 0", bif.busy); end
    endtask

    task automatic test_check_fail();
        int en, clr, dn, de;
        bif.signature = 5'h0B;
        pulse_start(1'b0, 1'b0);
        total++; if (bif.pass !== 1'b0) begin bad++; $display("FAIL cf_pass_cleared: got %b want 0", bif.pass); end
        run_measure(0, en, clr, dn, de);
        total++; if (dn !== 1) begin bad++; $display("FAIL cf_done_pulses: got %0d want 1", dn); end
        total++; if (bif.sig_cap !== 5'h0B) begin bad++; $display("FAIL cf_sig_cap: got %h want 0b", bif.sig_cap); end
        total++; if (bif.pass !== 1'b0) begin bad++; $display("FAIL cf_pass: got %b want 0", bif.pass); end
        total++; if (bif.golden !== 5'h16) begin bad++; $display("FAIL cf_golden: got %h want 16", bif.golden); end
    endtask

    task automatic test_learn_then_check();
        int en, clr, dn, de;
        bif.signature = 5'h0B;
        pulse_start(1'b1, 1'b0);
        run_measure(0, en, clr, dn, de);
        total++; if (dn !== 1) begin bad++; $display("FAIL lc_learn_done: got %0d want 1", dn); end
        total++; if (bif.golden !== 5'h0B) begin bad++; $display("FAIL lc_golden_learned: got %h want 0b", bif.golden); end
        total++; if (bif.pass !== 1'b1) begin bad++; $display("FAIL lc_learn_pass: got %b want 1", bif.pass); end
        pulse_start(1'b0, 1'b0);
        total++; if (bif.pass !== 1'b0) begin bad++; $display("FAIL lc_pass_cleared: got %b want 0", bif.pass); end
        run_measure(0, en, clr, dn, de);
        total++; if (bif.pass !== 1'b1) begin bad++; $display("FAIL lc_check_pass: got %b want 1", bif.pass); end
        total++; if (bif.golden !== 5'h0B) begin bad++; $display("FAIL lc_golden_kept: got %h want 0b", bif.golden); end
        bif.signature = 5'h16;
        pulse_start(1'b0, 1'b0);
        run_measure(0, en, clr, dn, de);
        total++; if (bif.pass !== 1'b0) begin bad++; $display("FAIL lc_old_golden_fails: got %b want 0", bif.pass); end
        total++; if (bif.sig_cap !== 5'h16) begin bad++; $display("FAIL lc_sig_cap: got %h want 16", bif.sig_cap); end
    endtask

    task automatic test_abort();
        int en, clr, dn, de;
        int steps;
        int dn_after;
        bif.signature = 5'h0B;
        pulse_start(1'b0, 1'b0);
        run_measure(0, en, clr, dn, de);
        total++; if (bif.pass !== 1'b1) begin bad++; $display("FAIL ab_pre_pass: got %b want 1", bif.pass); end
        // Abort mid-run at cycle_cnt == 20.
        bif.signature = 5'h1F;
        pulse_start(1'b0, 1'b0);
        steps = 0;
        while (bif.cycle_cnt !== 16'd20 && steps < 100) begin
            tick();
            steps++;
        end
        total++; if (bif.cycle_cnt !== 16'd20) begin bad++; $display("FAIL ab_reach_20: got %0d want 20", bif.cycle_cnt); end
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;
        total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL ab_busy: got %b want 0", bif.busy); end
        total++; if (bif.chain_en !== 1'b0) begin bad++; $display("FAIL ab_chain_en: got %b want 0", bif.chain_en); end
        total++; if (bif.cycle_cnt !== 16'd21) begin bad++; $display("FAIL ab_cycle_cnt: got %0d want 21", bif.cycle_cnt); end
        total++; if (bif.pass !== 1'b0) begin bad++; $display("FAIL ab_pass: got %b want 0", bif.pass); end
        total++; if (bif.sig_cap !== 5'h0B) begin bad++; $display("FAIL ab_sig_cap_kept: got %h want 0b", bif.sig_cap); end
        total++; if (bif.golden !== 5'h0B) begin bad++; $display("FAIL ab_golden_kept: got %h want 0b", bif.golden); end
        dn_after = 0;
        for (int k = 0; k < 70; k++) begin
            if (bif.done) dn_after++;
            tick();
        end
        total++; if (dn_after !== 0) begin bad++; $display("FAIL ab_no_done: got %0d want 0", dn_after); end
        total++; if (bif.cycle_cnt !== 16'd21) begin bad++; $display("FAIL ab_cnt_holds: got %0d want 21", bif.cycle_cnt); end
        // Abort while in CLEAR.
        pulse_start(1'b0, 1'b0);
        bif.abort = 1'b1;
        tick();
        bif.abort = 1'b0;
        total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL ab_clear_busy: got %b want 0", bif.busy); end
        total++; if (bif.cycle_cnt !== 16'd0) begin bad++; $display("FAIL ab_clear_cnt: got %0d want 0", bif.cycle_cnt); end
        // Abort in IDLE alongside start: start wins, and the fresh run passes.
        bif.signature = 5'h0B;
        pulse_start(1'b0, 1'b1);
        total++; if (bif.busy !== 1'b1) begin bad++; $display("FAIL ab_start_wins: got %b want 1", bif.busy); end
        run_measure(0, en, clr, dn, de);
        total++; if (en !== 64) begin bad++; $display("FAIL ab_fresh_en: got %0d want 64", en); end
        total++; if (dn !== 1) begin bad++; $display("FAIL ab_fresh_done: got %0d want 1", dn); end
        total++; if (bif.pass !== 1'b1) begin bad++; $display("FAIL ab_fresh_pass: got %b want 1", bif.pass); end
    endtask

    task automatic test_back_to_back();
        int en, clr, dn, de;
        bif.signature = 5'h0B;
        pulse_start(1'b0, 1'b0);
        run_measure(10, en, clr, dn, de);
        total++; if (en !== 64) begin bad++; $display("FAIL bb_en_cycles: got %0d want 64", en); end
        total++; if (clr !== 0) begin bad++; $display("FAIL bb_no_reclear: got %0d want 0", clr); end
        total++; if (dn !== 1) begin bad++; $display("FAIL bb_done_pulses: got %0d want 1", dn); end
        total++; if (de !== 66) begin bad++; $display("FAIL bb_done_edge: got %0d want 66", de); end
        total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL bb_not_queued: got %b want 0", bif.busy); end
    endtask

    task automatic test_async_reset();
        int en, clr, dn, de;
        int steps;
        bif.signature = 5'h05;
        pulse_start(1'b1, 1'b0);
        run_measure(0, en, clr, dn, de);
        total++; if (bif.golden !== 5'h05) begin bad++; $display("FAIL ar_learn_golden: got %h want 05", bif.golden); end
        pulse_start(1'b0, 1'b0);
        steps = 0;
        while (bif.cycle_cnt !== 16'd30 && steps < 100) begin
            tick();
            steps++;
        end
        total++; if (bif.cycle_cnt !== 16'd30) begin bad++; $display("FAIL ar_reach_30: got %0d want 30", bif.cycle_cnt); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (bif.chain_en !== 1'b0) begin bad++; $display("FAIL ar_chain_en: got %b want 0", bif.chain_en); end
        total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL ar_busy: got %b want 0", bif.busy); end
        total++; if (bif.golden !== 5'h16) begin bad++; $display("FAIL ar_golden: got %h want 16", bif.golden); end
        total++; if (bif.cycle_cnt !== 16'd0) begin bad++; $display("FAIL ar_cycle_cnt: got %0d want 0", bif.cycle_cnt); end
        total++; if (bif.sig_cap !== 5'h00) begin bad++; $display("FAIL ar_sig_cap: got %h want 00", bif.sig_cap); end
        total++; if (bif.pass !== 1'b0) begin bad++; $display("FAIL ar_pass: got %b want 0", bif.pass); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        bif.signature = 5'h16;
        pulse_start(1'b0, 1'b0);
        run_measure(0, en, clr, dn, de);
        total++; if (en !== 64) begin bad++; $display("FAIL ar_restart_en: got %0d want 64", en); end
        total++; if (dn !== 1) begin bad++; $display("FAIL ar_restart_done: got %0d want 1", dn); end
        total++; if (bif.pass !== 1'b1) begin bad++; $display("FAIL ar_restart_pass: got %b want 1", bif.pass); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bif.start = 1'b0; bif.learn = 1'b0; bif.abort = 1'b0; bif.signature = '0;
        @(negedge clk);
        test_reset();
        test_check_pass();
        test_check_fail();
        test_learn_then_check();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
